// File: rtl/muldiv_iter_unit_if.sv
// rtl/muldiv_iter_unit_if.sv - request/response bundle between pipeline and mult/div unit
interface muldiv_iter_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/muldiv_iter_unit.sv
// rtl/muldiv_iter_unit.sv - iterative signed shift-add multiplier / restoring divider
module muldiv_iter_unit #(
    parameter int WIDTH = 32
) (
    input logic               clock,
    input logic               reset,
    muldiv_iter_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   opnd;
    logic               neg;
    logic               is_div;
    logic               div_zero;
    logic               div_ovf;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quot;
    logic               mul_ovf;

    // Magnitudes: the most negative value maps onto itself, which is the correct unsigned magnitude.
    always_comb begin
        abs_a = bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + 1'b1) : bus.data_operandA;
        abs_b = bus.data_operandB[WIDTH-1] ? (~bus.data_operandB + 1'b1) : bus.data_operandB;
    end

    // hi/lo is shared: product accumulator + multiplier for MUL, remainder + dividend/quotient for DIV.
    always_comb begin
        mul_sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        div_shift   = {hi, lo[WIDTH-1]};
        div_diff    = div_shift - {1'b0, opnd};
        div_ok      = ~div_diff[WIDTH];
        prod_signed = neg ? (~{hi, lo} + 1'b1) : {hi, lo};
        quot        = neg ? (~lo + 1'b1) : lo;
        mul_ovf     = ~(&prod_signed[2*WIDTH-1:WIDTH-1]) & (|prod_signed[2*WIDTH-1:WIDTH-1]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            count              <= '0;
            hi                 <= '0;
            lo                 <= '0;
            opnd               <= '0;
            neg                <= 1'b0;
            is_div             <= 1'b0;
            div_zero           <= 1'b0;
            div_ovf            <= 1'b0;
            bus.data_result    <= '0;
            bus.data_exception <= 1'b0;
            bus.data_resultRDY <= 1'b0;
            bus.busy           <= 1'b0;
        end else begin
            bus.data_resultRDY <= 1'b0;
            // A request in any state restarts from scratch; multiply has priority.
            if (bus.ctrl_MULT || bus.ctrl_DIV) begin
                state    <= bus.ctrl_MULT ? MUL : DIV;
                is_div   <= ~bus.ctrl_MULT;
                count    <= CW'(WIDTH);
                bus.busy <= 1'b1;
                hi       <= '0;
                lo       <= bus.ctrl_MULT ? abs_b : abs_a;
                opnd     <= bus.ctrl_MULT ? abs_a : abs_b;
                neg      <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                div_zero <= (bus.data_operandB == '0);
                div_ovf  <= (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                            (bus.data_operandB == '1);
            end else begin
                case (state)
                    MUL: begin
                        {hi, lo} <= {mul_sum, lo[WIDTH-1:1]};
                        count    <= count - 1'b1;
                        if (count == CW'(1)) begin
                            state    <= DONE;
                            bus.busy <= 1'b0;
                        end
                    end
                    DIV: begin
                        hi    <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        lo    <= {lo[WIDTH-2:0], div_ok};
                        count <= count - 1'b1;
                        if (count == CW'(1)) begin
                            state    <= DONE;
                            bus.busy <= 1'b0;
                        end
                    end
                    DONE: begin
                        state              <= IDLE;
                        bus.data_resultRDY <= 1'b1;
                        if (is_div) begin
                            bus.data_result    <= div_zero ? '0 : quot;
                            bus.data_exception <= div_zero | div_ovf;
                        end else begin
                            bus.data_result    <= prod_signed[WIDTH-1:0];
                            bus.data_exception <= mul_ovf;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_muldiv_iter_unit.sv
// tb/tb_muldiv_iter_unit.sv - scoreboard bench for muldiv_iter_unit
module tb_muldiv_iter_unit;
    localparam int LAT = 33;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          due;
    } exp_t;

    exp_t q[$];

    muldiv_iter_unit_if #(.WIDTH(32)) bus ();

    muldiv_iter_unit #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every RDY pulse must match the oldest outstanding expectation, including its deadline.
    always @(negedge clock) begin
        if (!reset && bus.data_resultRDY === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdy: got rdy=1 expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", bus.data_result, e.res);
                chk("exception", {31'b0, bus.data_exception}, {31'b0, e.exc});
                chk("latency_edge", cyc, e.due);
            end
        end
    end

    task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                            input bit expect_done, input logic [31:0] res, input bit exc);
        @(negedge clock);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        if (expect_done) q.push_back('{res: res, exc: exc, due: cyc + 1 + LAT});
        @(negedge clock);
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clock);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL timeout: got %0d pending results expected 0", q.size());
            q.delete();
        end
        repeat (2) @(negedge clock);
    endtask

    initial begin
        int busy_cnt;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_result", bus.data_result, 32'h0);
        chk("reset_exception", {31'b0, bus.data_exception}, 32'h0);
        chk("reset_rdy", {31'b0, bus.data_resultRDY}, 32'h0);
        chk("reset_busy", {31'b0, bus.busy}, 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        start_op(1, 0, 32'd7, 32'hFFFF_FFFA, 1, 32'hFFFF_FFD6, 0);
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(negedge clock);
        end
        chk("busy_cycles", busy_cnt, 32'd32);
        wait_idle();

        start_op(1, 0, 32'h0001_0000, 32'h0001_0000, 1, 32'h0000_0000, 1);
        wait_idle();
        start_op(1, 0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1, 32'h8000_0001, 0);
        wait_idle();

        start_op(0, 1, 32'hFFFF_FFEF, 32'd5, 1, 32'hFFFF_FFFD, 0);
        wait_idle();
        repeat (5) @(negedge clock);
        chk("hold_result", bus.data_result, 32'hFFFF_FFFD);
        start_op(0, 1, 32'd100, 32'd0, 1, 32'h0, 1);
        wait_idle();
        start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1);
        wait_idle();

        // Second request lands mid-operation; only its result may appear.
        start_op(1, 0, 32'd3, 32'd4, 0, 32'h0, 0);
        repeat (8) @(negedge clock);
        start_op(0, 1, 32'd20, 32'd4, 1, 32'd5, 0);
        wait_idle();

        start_op(1, 1, 32'd6, 32'd3, 1, 32'd18, 0);
        wait_idle();

        start_op(0, 1, 32'd50, 32'd7, 0, 32'h0, 0);
        repeat (13) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_result", bus.data_result, 32'h0);
        chk("abort_exception", {31'b0, bus.data_exception}, 32'h0);
        chk("abort_rdy", {31'b0, bus.data_resultRDY}, 32'h0);
        chk("abort_busy", {31'b0, bus.busy}, 32'h0);
        reset = 1'b0;
        repeat (40) @(negedge clock);

        start_op(1, 0, 32'd2, 32'd2, 1, 32'd4, 0);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
